// File: rtl/mcpu_pkg.sv
// mcpu_pkg: shared state encodings, opcode/funct constants,
// ALU operation codes and mux selects for the multicycle MIPS controller.
package mcpu_pkg;

  typedef enum logic [3:0] {
    S_IF    = 4'd0,
    S_ID    = 4'd1,
    S_MADDR = 4'd2,
    S_MRD   = 4'd3,
    S_LWB   = 4'd4,
    S_MWR   = 4'd5,
    S_REX   = 4'd6,
    S_RWB   = 4'd7,
    S_BR    = 4'd8,
    S_J     = 4'd9,
    S_IEX   = 4'd10,
    S_IWB   = 4'd11,
    S_LUI   = 4'd12,
    S_JAL   = 4'd13,
    S_JR    = 4'd14,
    S_ERR   = 4'd15
  } state_e;

  typedef enum logic [3:0] {
    CL_BAD,
    CL_MEM,
    CL_R,
    CL_JR,
    CL_BR,
    CL_J,
    CL_JAL,
    CL_I,
    CL_LUI
  } iclass_e;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_JAL  = 6'b000011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_SLTI = 6'b001010;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_XORI = 6'b001110;
  localparam logic [5:0] OP_LUI  = 6'b001111;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;

  localparam logic [5:0] FN_SRL = 6'b000010;
  localparam logic [5:0] FN_JR  = 6'b001000;
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_XOR = 6'b100110;
  localparam logic [5:0] FN_NOR = 6'b100111;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_XOR = 3'b011;
  localparam logic [2:0] ALU_NOR = 3'b100;
  localparam logic [2:0] ALU_SRL = 3'b101;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] SRCB_RT   = 2'b00;
  localparam logic [1:0] SRCB_4    = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] SRCB_IMM4 = 2'b11;

  localparam logic [1:0] PCS_ALU  = 2'b00;
  localparam logic [1:0] PCS_AOUT = 2'b01;
  localparam logic [1:0] PCS_JMP  = 2'b10;
  localparam logic [1:0] PCS_RS   = 2'b11;

  localparam logic [1:0] WB_AOUT = 2'b00;
  localparam logic [1:0] WB_MDR  = 2'b01;
  localparam logic [1:0] WB_LUI  = 2'b10;
  localparam logic [1:0] WB_PC   = 2'b11;

endpackage

// File: rtl/mcpu_ctrl_if.sv
// mcpu_ctrl_if: controller <-> datapath bundle.
// master = controller (drives strobes/selects), slave = datapath.
interface mcpu_ctrl_if;
  logic [5:0] OPcode;
  logic [5:0] Fun;
  logic       zero;
  logic       MIO_ready;
  logic       PCWrite;
  logic       IorD;
  logic       MemRead;
  logic       MemWrite;
  logic       IRWrite;
  logic       RegWrite;
  logic       RegDst;
  logic [1:0] DatatoReg;
  logic       Jal;
  logic [2:0] ALU_Control;
  logic       ALUSrc_A;
  logic [1:0] ALUSrc_B;
  logic [1:0] PCSource;
  logic       err;
  logic [3:0] state;

  modport master (
    input  OPcode, Fun, zero, MIO_ready,
    output PCWrite, IorD, MemRead, MemWrite,
    output IRWrite, RegWrite, RegDst, DatatoReg,
    output Jal, ALU_Control, ALUSrc_A, ALUSrc_B,
    output PCSource, err, state
  );

  modport slave (
    output OPcode, Fun, zero, MIO_ready,
    input  PCWrite, IorD, MemRead, MemWrite,
    input  IRWrite, RegWrite, RegDst, DatatoReg,
    input  Jal, ALU_Control, ALUSrc_A, ALUSrc_B,
    input  PCSource, err, state
  );
endinterface

// File: rtl/mcpu_decode.sv
// mcpu_decode: classifies opcode/funct and selects R/I-type ALU ops.
// in: opcode, fun; out: iclass, is_sw, is_bne, r_alu, i_alu.
module mcpu_decode
  import mcpu_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] fun,
  output iclass_e    iclass,
  output logic       is_sw,
  output logic       is_bne,
  output logic [2:0] r_alu,
  output logic [2:0] i_alu
);

  assign is_sw  = (opcode == OP_SW);
  assign is_bne = (opcode == OP_BNE);

  always_comb begin
    iclass = CL_BAD;
    r_alu  = ALU_ADD;
    unique case (opcode)
      OP_LW, OP_SW:   iclass = CL_MEM;
      OP_BEQ, OP_BNE: iclass = CL_BR;
      OP_J:           iclass = CL_J;
      OP_JAL:         iclass = CL_JAL;
      OP_LUI:         iclass = CL_LUI;
      OP_ADDI, OP_SLTI, OP_ANDI,
      OP_ORI, OP_XORI: iclass = CL_I;
      OP_R: begin
        unique case (fun)
          FN_ADD: begin iclass = CL_R; r_alu = ALU_ADD; end
          FN_SUB: begin iclass = CL_R; r_alu = ALU_SUB; end
          FN_AND: begin iclass = CL_R; r_alu = ALU_AND; end
          FN_OR:  begin iclass = CL_R; r_alu = ALU_OR;  end
          FN_XOR: begin iclass = CL_R; r_alu = ALU_XOR; end
          FN_NOR: begin iclass = CL_R; r_alu = ALU_NOR; end
          FN_SLT: begin iclass = CL_R; r_alu = ALU_SLT; end
          FN_SRL: begin iclass = CL_R; r_alu = ALU_SRL; end
          FN_JR:  iclass = CL_JR;
          default: iclass = CL_BAD;
        endcase
      end
      default: iclass = CL_BAD;
    endcase
  end

  always_comb begin
    i_alu = ALU_ADD;
    unique case (opcode)
      OP_SLTI: i_alu = ALU_SLT;
      OP_ANDI: i_alu = ALU_AND;
      OP_ORI:  i_alu = ALU_OR;
      OP_XORI: i_alu = ALU_XOR;
      default: i_alu = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mcpu_ctrl.sv
// mcpu_ctrl: multicycle MIPS control FSM with combinational output decode.
// ports: clk, rst (sync, active-high), bus (mcpu_ctrl_if.master).
module mcpu_ctrl
  import mcpu_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  mcpu_ctrl_if.master      bus
);

  state_e     state_q, state_d;
  iclass_e    iclass;
  logic       is_sw, is_bne;
  logic [2:0] r_alu, i_alu;

  logic       pc_wr, iord, mem_rd, mem_wr;
  logic       ir_wr, reg_wr, reg_dst, jal;
  logic       src_a, err;
  logic [1:0] d2r, src_b, pc_src;
  logic [2:0] alu;

  mcpu_decode u_dec (
    .opcode (bus.OPcode),
    .fun    (bus.Fun),
    .iclass (iclass),
    .is_sw  (is_sw),
    .is_bne (is_bne),
    .r_alu  (r_alu),
    .i_alu  (i_alu)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IF;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    pc_wr   = 1'b0;
    iord    = 1'b0;
    mem_rd  = 1'b0;
    mem_wr  = 1'b0;
    ir_wr   = 1'b0;
    reg_wr  = 1'b0;
    reg_dst = 1'b0;
    jal     = 1'b0;
    src_a   = 1'b0;
    err     = 1'b0;
    d2r     = WB_AOUT;
    src_b   = SRCB_RT;
    pc_src  = PCS_ALU;
    alu     = ALU_AND;
    unique case (state_q)
      S_IF: begin
        mem_rd = 1'b1;
        src_b  = SRCB_4;
        alu    = ALU_ADD;
        ir_wr  = bus.MIO_ready;
        pc_wr  = bus.MIO_ready;
        if (bus.MIO_ready) state_d = S_ID;
      end
      S_ID: begin
        // precompute branch target into ALUOut
        src_b = SRCB_IMM4;
        alu   = ALU_ADD;
        unique case (iclass)
          CL_MEM:  state_d = S_MADDR;
          CL_R:    state_d = S_REX;
          CL_JR:   state_d = S_JR;
          CL_BR:   state_d = S_BR;
          CL_J:    state_d = S_J;
          CL_JAL:  state_d = S_JAL;
          CL_I:    state_d = S_IEX;
          CL_LUI:  state_d = S_LUI;
          default: state_d = S_ERR;
        endcase
      end
      S_MADDR: begin
        src_a   = 1'b1;
        src_b   = SRCB_IMM;
        alu     = ALU_ADD;
        state_d = is_sw ? S_MWR : S_MRD;
      end
      S_MRD: begin
        iord   = 1'b1;
        mem_rd = 1'b1;
        if (bus.MIO_ready) state_d = S_LWB;
      end
      S_LWB: begin
        d2r     = WB_MDR;
        reg_wr  = 1'b1;
        state_d = S_IF;
      end
      S_MWR: begin
        iord   = 1'b1;
        mem_wr = 1'b1;
        if (bus.MIO_ready) state_d = S_IF;
      end
      S_REX: begin
        src_a   = 1'b1;
        alu     = r_alu;
        state_d = S_RWB;
      end
      S_RWB: begin
        reg_dst = 1'b1;
        reg_wr  = 1'b1;
        state_d = S_IF;
      end
      S_BR: begin
        src_a   = 1'b1;
        alu     = ALU_SUB;
        pc_src  = PCS_AOUT;
        pc_wr   = is_bne ? ~bus.zero : bus.zero;
        state_d = S_IF;
      end
      S_IEX: begin
        src_a   = 1'b1;
        src_b   = SRCB_IMM;
        alu     = i_alu;
        state_d = S_IWB;
      end
      S_IWB: begin
        reg_wr  = 1'b1;
        state_d = S_IF;
      end
      S_LUI: begin
        d2r     = WB_LUI;
        reg_wr  = 1'b1;
        state_d = S_IF;
      end
      S_J: begin
        pc_src  = PCS_JMP;
        pc_wr   = 1'b1;
        state_d = S_IF;
      end
      S_JR: begin
        pc_src  = PCS_RS;
        pc_wr   = 1'b1;
        state_d = S_IF;
      end
      S_JAL: begin
        pc_src  = PCS_JMP;
        pc_wr   = 1'b1;
        reg_wr  = 1'b1;
        d2r     = WB_PC;
        jal     = 1'b1;
        state_d = S_IF;
      end
      S_ERR: begin
        err     = 1'b1;
        state_d = S_ERR;
      end
    endcase
  end

  // strobes are gated by rst so a reset mid-access never
  // commits a write, even while the state still shows MRD/MWR
  assign bus.PCWrite     = pc_wr  & ~rst;
  assign bus.IRWrite     = ir_wr  & ~rst;
  assign bus.MemRead     = mem_rd & ~rst;
  assign bus.MemWrite    = mem_wr & ~rst;
  assign bus.RegWrite    = reg_wr & ~rst;
  assign bus.IorD        = iord;
  assign bus.RegDst      = reg_dst;
  assign bus.DatatoReg   = d2r;
  assign bus.Jal         = jal;
  assign bus.ALU_Control = alu;
  assign bus.ALUSrc_A    = src_a;
  assign bus.ALUSrc_B    = src_b;
  assign bus.PCSource    = pc_src;
  assign bus.err         = err;
  assign bus.state       = state_q;

endmodule

// File: tb/tb_mcpu_ctrl.sv
// tb_mcpu_ctrl: directed-vector bench for mcpu_ctrl.
// Each task starts in an unclocked IF cycle and ends in one.
module tb_mcpu_ctrl;

  logic clk = 1'b0;
  logic rst;
  int   tests = 0;
  int   fails = 0;

  mcpu_ctrl_if bus ();

  mcpu_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic test_reset();
    rst = 1'b1;
    bus.OPcode = 6'd0;
    bus.Fun = 6'd0;
    bus.zero = 1'b0;
    bus.MIO_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    #1;
    tests++;
    if (bus.state !== 4'd0) begin
      fails++;
      $display("FAIL rst_state: got %0d exp 0", bus.state);
    end
    tests++;
    if ({bus.PCWrite, bus.IRWrite, bus.MemRead,
         bus.MemWrite, bus.RegWrite} !== 5'b0) begin
      fails++;
      $display("FAIL rst_strobes: got %b exp 00000",
        {bus.PCWrite, bus.IRWrite, bus.MemRead,
         bus.MemWrite, bus.RegWrite});
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    tests++;
    if (bus.state !== 4'd0 || bus.MemRead !== 1'b1 ||
        bus.IRWrite !== 1'b1 || bus.ALUSrc_B !== 2'b01) begin
      fails++;
      $display("FAIL rst_first_if: st=%0d mr=%b ir=%b b=%b exp 0 1 1 01",
        bus.state, bus.MemRead, bus.IRWrite, bus.ALUSrc_B);
    end
  endtask

  task automatic test_rtype();
    logic [5:0] fn [4] = '{6'b100000, 6'b100010, 6'b000010, 6'b100111};
    logic [2:0] op [4] = '{3'b010, 3'b110, 3'b101, 3'b100};
    logic [3:0] es [5] = '{4'd0, 4'd1, 4'd6, 4'd7, 4'd0};
    for (int k = 0; k < 4; k++) begin
      bus.OPcode = 6'd0;
      bus.Fun = fn[k];
      bus.MIO_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
        if (i > 0) @(negedge clk);
        #1;
        tests++;
        if (bus.state !== es[i]) begin
          fails++;
          $display("FAIL rtype%0d_state[%0d]: got %0d exp %0d",
            k, i, bus.state, es[i]);
        end
        tests++;
        if (bus.RegWrite !== (es[i] == 4'd7) ||
            bus.RegDst !== (es[i] == 4'd7)) begin
          fails++;
          $display("FAIL rtype%0d_wb[%0d]: rw=%b rd=%b exp %b",
            k, i, bus.RegWrite, bus.RegDst, es[i] == 4'd7);
        end
        if (es[i] == 4'd6) begin
          tests++;
          if (bus.ALU_Control !== op[k] || bus.ALUSrc_A !== 1'b1 ||
              bus.ALUSrc_B !== 2'b00) begin
            fails++;
            $display("FAIL rtype%0d_rex: alu=%b a=%b b=%b exp %b 1 00",
              k, bus.ALU_Control, bus.ALUSrc_A, bus.ALUSrc_B, op[k]);
          end
        end
      end
    end
  endtask

  task automatic test_lw_wait();
    logic       rd [8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [3:0] es [8] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd3, 4'd3, 4'd4, 4'd0};
    bus.OPcode = 6'b100011;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) @(negedge clk);
      bus.MIO_ready = rd[i];
      #1;
      tests++;
      if (bus.state !== es[i]) begin
        fails++;
        $display("FAIL lw_state[%0d]: got %0d exp %0d", i, bus.state, es[i]);
      end
      if (es[i] == 4'd3) begin
        tests++;
        if (bus.MemRead !== 1'b1 || bus.IorD !== 1'b1 ||
            bus.RegWrite !== 1'b0) begin
          fails++;
          $display("FAIL lw_mrd[%0d]: mr=%b iord=%b rw=%b exp 1 1 0",
            i, bus.MemRead, bus.IorD, bus.RegWrite);
        end
      end
      if (es[i] == 4'd4) begin
        tests++;
        if (bus.DatatoReg !== 2'b01 || bus.RegWrite !== 1'b1 ||
            bus.RegDst !== 1'b0 || bus.MemRead !== 1'b0) begin
          fails++;
          $display("FAIL lw_lwb: d2r=%b rw=%b rd=%b mr=%b exp 01 1 0 0",
            bus.DatatoReg, bus.RegWrite, bus.RegDst, bus.MemRead);
        end
      end
    end
  endtask

  task automatic test_branch();
    logic [5:0] opc [3] = '{6'b000100, 6'b000101, 6'b000101};
    logic       z   [3] = '{1'b1, 1'b1, 1'b0};
    logic       pw  [3] = '{1'b1, 1'b0, 1'b1};
    logic [3:0] es  [4] = '{4'd0, 4'd1, 4'd8, 4'd0};
    bus.MIO_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      bus.OPcode = opc[k];
      bus.zero = z[k];
      for (int i = 0; i < 4; i++) begin
        if (i > 0) @(negedge clk);
        #1;
        tests++;
        if (bus.state !== es[i]) begin
          fails++;
          $display("FAIL br%0d_state[%0d]: got %0d exp %0d",
            k, i, bus.state, es[i]);
        end
        if (es[i] == 4'd8) begin
          tests++;
          if (bus.PCWrite !== pw[k] || bus.PCSource !== 2'b01 ||
              bus.ALU_Control !== 3'b110 || bus.ALUSrc_A !== 1'b1) begin
            fails++;
            $display("FAIL br%0d_br: pw=%b pcs=%b alu=%b a=%b exp %b 01 110 1",
              k, bus.PCWrite, bus.PCSource, bus.ALU_Control,
              bus.ALUSrc_A, pw[k]);
          end
        end
      end
    end
    bus.zero = 1'b0;
  endtask

  task automatic test_jump();
    logic [5:0] opc [3] = '{6'b000011, 6'b000010, 6'b000000};
    logic [3:0] xs  [3] = '{4'd13, 4'd9, 4'd14};
    logic [1:0] pcs [3] = '{2'b10, 2'b10, 2'b11};
    bus.MIO_ready = 1'b1;
    bus.Fun = 6'b001000;
    for (int k = 0; k < 3; k++) begin
      bus.OPcode = opc[k];
      for (int i = 0; i < 4; i++) begin
        if (i > 0) @(negedge clk);
        #1;
        tests++;
        if (bus.state !== ((i == 2) ? xs[k] : ((i == 1) ? 4'd1 : 4'd0))) begin
          fails++;
          $display("FAIL jmp%0d_state[%0d]: got %0d", k, i, bus.state);
        end
        if (i == 2) begin
          tests++;
          if (bus.PCWrite !== 1'b1 || bus.PCSource !== pcs[k] ||
              bus.RegWrite !== (k == 0) || bus.Jal !== (k == 0) ||
              bus.DatatoReg !== ((k == 0) ? 2'b11 : 2'b00)) begin
            fails++;
            $display("FAIL jmp%0d_out: pw=%b pcs=%b rw=%b jal=%b d2r=%b",
              k, bus.PCWrite, bus.PCSource, bus.RegWrite,
              bus.Jal, bus.DatatoReg);
          end
        end
      end
    end
  endtask

  task automatic test_itype();
    logic [3:0] es [5] = '{4'd0, 4'd1, 4'd10, 4'd11, 4'd0};
    bus.MIO_ready = 1'b1;
    bus.OPcode = 6'b001010;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      tests++;
      if (bus.state !== es[i]) begin
        fails++;
        $display("FAIL slti_state[%0d]: got %0d exp %0d", i, bus.state, es[i]);
      end
      if (i == 2) begin
        tests++;
        if (bus.ALU_Control !== 3'b111 || bus.ALUSrc_B !== 2'b10 ||
            bus.ALUSrc_A !== 1'b1 || bus.RegWrite !== 1'b0) begin
          fails++;
          $display("FAIL slti_iex: alu=%b b=%b a=%b rw=%b exp 111 10 1 0",
            bus.ALU_Control, bus.ALUSrc_B, bus.ALUSrc_A, bus.RegWrite);
        end
      end
      if (i == 3) begin
        tests++;
        if (bus.RegWrite !== 1'b1 || bus.RegDst !== 1'b0 ||
            bus.DatatoReg !== 2'b00) begin
          fails++;
          $display("FAIL slti_iwb: rw=%b rd=%b d2r=%b exp 1 0 00",
            bus.RegWrite, bus.RegDst, bus.DatatoReg);
        end
      end
    end
    bus.OPcode = 6'b001111;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      tests++;
      if (bus.state !== ((i == 2) ? 4'd12 : ((i == 1) ? 4'd1 : 4'd0))) begin
        fails++;
        $display("FAIL lui_state[%0d]: got %0d", i, bus.state);
      end
      if (i == 2) begin
        tests++;
        if (bus.DatatoReg !== 2'b10 || bus.RegWrite !== 1'b1 ||
            bus.PCWrite !== 1'b0) begin
          fails++;
          $display("FAIL lui_out: d2r=%b rw=%b pw=%b exp 10 1 0",
            bus.DatatoReg, bus.RegWrite, bus.PCWrite);
        end
      end
    end
  endtask

  task automatic test_err();
    bus.MIO_ready = 1'b1;
    bus.OPcode = 6'b111111;
    @(negedge clk);
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      tests++;
      if (bus.state !== 4'd15 || bus.err !== 1'b1 ||
          {bus.PCWrite, bus.IRWrite, bus.MemRead,
           bus.MemWrite, bus.RegWrite} !== 5'b0) begin
        fails++;
        $display("FAIL err_hold[%0d]: st=%0d err=%b strobes=%b exp 15 1 0",
          i, bus.state, bus.err,
          {bus.PCWrite, bus.IRWrite, bus.MemRead,
           bus.MemWrite, bus.RegWrite});
      end
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    tests++;
    if (bus.state !== 4'd0 || bus.err !== 1'b0 ||
        bus.MemRead !== 1'b1) begin
      fails++;
      $display("FAIL err_reset: st=%0d err=%b mr=%b exp 0 0 1",
        bus.state, bus.err, bus.MemRead);
    end
  endtask

  task automatic test_sw_reset();
    logic [3:0] es [5] = '{4'd0, 4'd1, 4'd2, 4'd5, 4'd0};
    bus.OPcode = 6'b101011;
    bus.MIO_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      tests++;
      if (bus.state !== es[i] || bus.MemWrite !== (es[i] == 4'd5)) begin
        fails++;
        $display("FAIL sw_state[%0d]: st=%0d mw=%b exp %0d %b",
          i, bus.state, bus.MemWrite, es[i], es[i] == 4'd5);
      end
    end
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clk);
      bus.MIO_ready = (i < 3);
      #1;
    end
    tests++;
    if (bus.state !== 4'd5 || bus.MemWrite !== 1'b1 ||
        bus.IorD !== 1'b1) begin
      fails++;
      $display("FAIL swr_mwr: st=%0d mw=%b iord=%b exp 5 1 1",
        bus.state, bus.MemWrite, bus.IorD);
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    tests++;
    if (bus.state !== 4'd5 || bus.MemWrite !== 1'b0) begin
      fails++;
      $display("FAIL swr_rst: st=%0d mw=%b exp 5 0", bus.state, bus.MemWrite);
    end
    @(negedge clk);
    rst = 1'b0;
    bus.MIO_ready = 1'b1;
    #1;
    tests++;
    if (bus.state !== 4'd0 || bus.MemRead !== 1'b1 ||
        bus.MemWrite !== 1'b0) begin
      fails++;
      $display("FAIL swr_if: st=%0d mr=%b mw=%b exp 0 1 0",
        bus.state, bus.MemRead, bus.MemWrite);
    end
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_lw_wait();
    test_branch();
    test_jump();
    test_itype();
    test_err();
    test_sw_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
